write_control_top_1: RTL and testbench
======================================

// Module: write_control_top_1
// PURPOSE
//  Write-side pointer/flag controller for the FIFO; pairs with the read-side controller.
//  - Keeps the binary write pointer and advances it on each accepted write.
//  - Generates the registered f_full flag.
//  - Synchronises the read-domain Gray pointer into wr_clk.
//  - Exports a Gray write pointer for the read domain to synchronise.
//  Sits between the producer interface and the dual-port RAM write port in FIFO_top_1.
// PARAMETERS
//  A_LENGTH       4   RAM address width (= `a_length); depth = 2**A_LENGTH; pointers are A_LENGTH+1 bits
//  SYNC_STAGES    2   flop stages on rd_ptr_gray crossing into wr_clk (legal range 2..3)
//  ALMOST_FULL_TH 14  occupancy at or above which almost_full asserts (1..2**A_LENGTH)
// PORTS
//  wr_clk       in   1           write clock (only clock)
//  reset        in   1           synchronous, active-high reset
//  wr_en        in   1           producer write request
//  rd_ptr_gray  in   A_LENGTH+1  Gray read pointer from the read domain (asynchronous)
//  wr_accept    out  1           combinational: wr_en & ~f_full; RAM write strobe
//  f_full       out  1           registered full flag
//  almost_full  out  1           registered: occupancy >= ALMOST_FULL_TH
//  overflow     out  1           sticky: a write was attempted while f_full
//  MSB_wr_ptr   out  1           wr_ptr[A_LENGTH] (wrap bit)
//  b_wr_ptr     out  A_LENGTH    wr_ptr[A_LENGTH-1:0]; RAM write address
//  wr_ptr       out  A_LENGTH+1  binary write pointer
//  wr_ptr_gray  out  A_LENGTH+1  registered Gray of wr_ptr, for the read domain
// BEHAVIOUR
//  - Reset (sync, high) forces these to 0: wr_ptr, wr_ptr_gray, all sync stages, f_full,
//    almost_full, overflow. Takes priority over every other event in that cycle.
//  - wr_ptr_next = wr_ptr + wr_accept, computed modulo 2**(A_LENGTH+1).
//    - 2**(A_LENGTH+1)-1 wraps to 0 silently.
//    - MSB toggles at each pass through depth.
//  - wr_ptr <= wr_ptr_next, so b_wr_ptr addresses the current write in the same cycle as wr_accept.
//  - wr_ptr_gray <= wr_ptr_next ^ (wr_ptr_next >> 1).
//    - Registered, so it is glitch-free and at most 1 bit changes per edge.
//  - Sync chain: rq[0] <= rd_ptr_gray; rq[i] <= rq[i-1]; rq_sync = rq[SYNC_STAGES-1].
//  - Full detect: f_full <= (gray(wr_ptr_next) == {~rq_sync[A:A-1], rq_sync[A-2:0]}).
//    - Requires A_LENGTH >= 2.
//    - f_full asserts on the same edge on which wr_ptr reaches full; no write slips through.
//  - Full release: after rd_ptr_gray advances, f_full drops SYNC_STAGES+1 wr_clk edges later
//    (3 edges by default). This release is pessimistic and never optimistic.
//  - Occupancy: occ = wr_ptr_next - gray2bin(rq_sync), A_LENGTH+1 bits, modulo arithmetic.
//    - almost_full <= (occ >= ALMOST_FULL_TH).
//  - overflow: set when wr_en & f_full; held until reset; wr_ptr does not move on such a write.
//  - Simultaneous write and read-pointer change in one cycle:
//    - wr_accept is decided on the current f_full only.
//    - The read change is seen only after synchronisation.
//  - Reset mid-operation: pointers return to 0 next edge regardless of wr_en.
//    - The read side must be reset in the same window.
//  - No state machine. State = pointer register, Gray register, sync chain, 3 flag flops.
// STRUCTURE
//  - Shared package / para.h holds: `a_length and the function pair bin2gray/gray2bin.
//    The read side reuses both.
//  - Sub-module gray_sync (parameterised width and stages) holds the rd_ptr_gray chain.
//    It is reused mirror-image in the read domain.
//  - Pointer register is local.
//  - binary_up_counter cannot be reused: it offers no next-state output for the flag lookahead.
// TESTING (A_LENGTH=4, default params, rd_ptr_gray held 0 unless stated)
//  1 reset=1 for 2 edges with wr_en=1
//    -> wr_ptr=0, wr_ptr_gray=0, all flags 0, wr_accept=1 but no increment while reset.
//  2 16 back-to-back writes
//    -> wr_ptr=0x10, MSB_wr_ptr=1, b_wr_ptr=0, wr_ptr_gray=0x18.
//    -> f_full=1 on the 16th edge; almost_full=1 from the 14th edge.
//  3 While full, wr_en=1 for 3 cycles
//    -> wr_accept=0, wr_ptr stays 0x10, overflow=1 and stays 1.
//  4 While full, set rd_ptr_gray=0x01
//    -> f_full=0 exactly 3 edges later; one write accepted; f_full=1 again next edge.
//  5 Interleave rd_ptr_gray updates to keep occupancy <=8; run 40 writes
//    -> wr_ptr wraps 0x1F->0x00; wr_ptr_gray 0x10->0x00; f_full never set.
//  6 reset pulse after 5 writes
//    -> next edge: wr_ptr=0, overflow=0, f_full=0, sync chain cleared.

Source files
------------

// File: rtl/write_control_top_1_pkg.sv
// -----------------------------------------------------------------------------
// write_control_top_1_pkg
// Shared definitions for the FIFO pointer controllers (write side and its
// mirror-image read side).
//   A_LENGTH_DEF : default RAM address width; pointers carry one extra wrap bit
//   GW           : working width of the Gray helpers; callers cast in and out
//   bin2gray     : binary -> reflected Gray code
//   gray2bin     : reflected Gray code -> binary
// -----------------------------------------------------------------------------
package write_control_top_1_pkg;

    localparam int A_LENGTH_DEF = 4;
    localparam int GW           = 32;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] gray);
        logic [GW-1:0] bin;
        bin[GW-1] = gray[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/write_control_top_1_if.sv
// -----------------------------------------------------------------------------
// write_control_top_1_if
// Producer / read-domain facing signals of the FIFO write controller.
//   wr_en        : producer write request
//   rd_ptr_gray  : Gray read pointer from the read domain (asynchronous)
//   wr_accept    : RAM write strobe (wr_en & ~f_full)
//   f_full       : registered full flag
//   almost_full  : registered occupancy >= threshold
//   overflow     : sticky, a write was attempted while full
//   MSB_wr_ptr   : wrap bit of the write pointer
//   b_wr_ptr     : RAM write address
//   wr_ptr       : binary write pointer
//   wr_ptr_gray  : registered Gray write pointer for the read domain
// master = producer side, slave = write controller.
// -----------------------------------------------------------------------------
interface write_control_top_1_if
    import write_control_top_1_pkg::*;
#(
    parameter int A_LENGTH = A_LENGTH_DEF
) ();

    logic                wr_en;
    logic [A_LENGTH:0]   rd_ptr_gray;
    logic                wr_accept;
    logic                f_full;
    logic                almost_full;
    logic                overflow;
    logic                MSB_wr_ptr;
    logic [A_LENGTH-1:0] b_wr_ptr;
    logic [A_LENGTH:0]   wr_ptr;
    logic [A_LENGTH:0]   wr_ptr_gray;

    modport master (
        output wr_en, rd_ptr_gray,
        input  wr_accept, f_full, almost_full, overflow,
               MSB_wr_ptr, b_wr_ptr, wr_ptr, wr_ptr_gray
    );

    modport slave (
        input  wr_en, rd_ptr_gray,
        output wr_accept, f_full, almost_full, overflow,
               MSB_wr_ptr, b_wr_ptr, wr_ptr, wr_ptr_gray
    );

endinterface

// File: rtl/write_control_top_1_gray_sync.sv
// -----------------------------------------------------------------------------
// write_control_top_1_gray_sync
// Multi-flop synchroniser for a Gray-coded pointer entering this clock domain.
// Only one bit of the input changes per source edge, so the flopped value is
// always either the old or the new pointer.
//   clk  : destination clock
//   srst : synchronous active-high reset, clears every stage
//   d_i  : asynchronous Gray pointer
//   q_o  : synchronised pointer (output of the last stage)
// -----------------------------------------------------------------------------
module write_control_top_1_gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;
            logic [WIDTH-1:0] stage_q;

            if (gi == 0) begin : g_first
                assign stage_d = d_i;
            end else begin : g_next
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign q_o = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/write_control_top_1.sv
// -----------------------------------------------------------------------------
// write_control_top_1
// Write-side pointer/flag controller of the asynchronous FIFO.
//   wr_clk : write clock
//   reset  : synchronous active-high reset
//   bus    : producer / read-domain signals (see write_control_top_1_if)
// Keeps the binary write pointer, exports its registered Gray image, brings the
// read Gray pointer across with a flop chain and derives full / almost_full /
// overflow from the next pointer value so the flags line up with the pointer.
// -----------------------------------------------------------------------------
module write_control_top_1
    import write_control_top_1_pkg::*;
#(
    parameter int A_LENGTH       = A_LENGTH_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int ALMOST_FULL_TH = 14
) (
    input logic                  wr_clk,
    input logic                  reset,
    write_control_top_1_if.slave bus
);

    localparam int               PTR_W = A_LENGTH + 1;
    localparam logic [PTR_W-1:0] AF_TH = PTR_W'(ALMOST_FULL_TH);

    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] rq_sync;
    logic [PTR_W-1:0] full_gray;
    logic [PTR_W-1:0] occ;
    logic             f_full_q,      f_full_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q,    overflow_d;
    logic             wr_accept;

    write_control_top_1_gray_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk  (wr_clk),
        .srst (reset),
        .d_i  (bus.rd_ptr_gray),
        .q_o  (rq_sync)
    );

    // Accept depends on the registered flag only; the flag already accounts
    // for the write that made the FIFO full.
    assign wr_accept = bus.wr_en & ~f_full_q;
    assign wr_ptr_d  = wr_ptr_q + PTR_W'(wr_accept);
    assign wr_gray_d = PTR_W'(bin2gray(GW'(wr_ptr_d)));

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that is the read pointer with its top two bits inverted.
    assign full_gray = {~rq_sync[A_LENGTH:A_LENGTH-1], rq_sync[A_LENGTH-2:0]};

    // Occupancy seen through the synchroniser; the read pointer lags, so this
    // can only overstate the fill level.
    assign occ = wr_ptr_d - PTR_W'(gray2bin(GW'(rq_sync)));

    assign f_full_d      = (wr_gray_d == full_gray);
    assign almost_full_d = (occ >= AF_TH);
    assign overflow_d    = overflow_q | (bus.wr_en & f_full_q);

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            wr_gray_q     <= '0;
            f_full_q      <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wr_gray_q     <= wr_gray_d;
            f_full_q      <= f_full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.wr_accept   = wr_accept;
    assign bus.f_full      = f_full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
    assign bus.MSB_wr_ptr  = wr_ptr_q[A_LENGTH];
    assign bus.b_wr_ptr    = wr_ptr_q[A_LENGTH-1:0];
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.wr_ptr_gray = wr_gray_q;

endmodule

// File: tb/tb_write_control_top_1.sv
// -----------------------------------------------------------------------------
// tb_write_control_top_1
// Bench for the FIFO write controller. A fill-level model (counts modulo one
// pointer lap, read pointer delayed by the synchroniser depth) predicts every
// output each cycle; directed sequences pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_write_control_top_1;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 1 << PW;
    localparam int SYNC  = 2;
    localparam int AF_TH = 14;

    logic wr_clk = 1'b0;
    logic reset  = 1'b1;

    always #5 wr_clk = ~wr_clk;

    write_control_top_1_if #(.A_LENGTH(AW)) bus ();

    write_control_top_1 #(
        .A_LENGTH       (AW),
        .SYNC_STAGES    (SYNC),
        .ALMOST_FULL_TH (AF_TH)
    ) dut (
        .wr_clk (wr_clk),
        .reset  (reset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    int m_ptr = 0;       // write pointer, 0..MOD-1
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;
    int rd_pipe[$];      // read pointers (binary) in flight through the synchroniser
    int rd_drv = 0;      // read pointer currently presented (binary)
    bit model_on = 0;
    int rsync, occ;
    bit acc;

    function automatic logic [PW-1:0] gray(input int b);
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: update on each edge, compare registered outputs 1 unit later.
    always @(posedge wr_clk) begin
        if (reset) begin
            m_ptr  = 0;
            m_full = 0;
            m_af   = 0;
            m_ovf  = 0;
            rd_pipe.delete();
            for (int i = 0; i < SYNC; i++) rd_pipe.push_back(0);
        end else begin
            acc   = bus.wr_en && !m_full;
            rsync = rd_pipe[SYNC-1];
            if (bus.wr_en && m_full) m_ovf = 1;
            m_ptr  = (m_ptr + int'(acc)) % MOD;
            occ    = (m_ptr - rsync + MOD) % MOD;
            m_full = (occ == DEPTH);
            m_af   = (occ >= AF_TH);
            rd_pipe.push_front(rd_drv);
            void'(rd_pipe.pop_back());
        end
        model_on = 1;
        #1;
        check("wr_ptr",      32'(bus.wr_ptr),      32'(m_ptr));
        check("wr_ptr_gray", 32'(bus.wr_ptr_gray), 32'(gray(m_ptr)));
        check("b_wr_ptr",    32'(bus.b_wr_ptr),    32'(m_ptr % DEPTH));
        check("MSB_wr_ptr",  32'(bus.MSB_wr_ptr),  32'(m_ptr / DEPTH));
        check("f_full",      32'(bus.f_full),      32'(m_full));
        check("almost_full", 32'(bus.almost_full), 32'(m_af));
        check("overflow",    32'(bus.overflow),    32'(m_ovf));
    end

    // Combinational strobe checked mid-cycle with the inputs for the next edge.
    always @(negedge wr_clk) begin
        if (model_on) begin
            check("wr_accept", 32'(bus.wr_accept), 32'(bus.wr_en && !m_full));
        end
    end

    // Present inputs, then advance one edge; returns 2 units after the edge.
    task automatic step(input bit rst, input bit we, input int rd);
        reset           = rst;
        bus.wr_en       = we;
        rd_drv          = rd;
        bus.rd_ptr_gray = gray(rd);
        @(posedge wr_clk);
        #2;
    endtask

    initial begin
        int n;
        int rd_cur;
        int wcnt;
        bit saw_full;

        // 1: reset held with wr_en high
        step(1, 1, 0);
        step(1, 1, 0);
        check("t1_wr_ptr",    32'(bus.wr_ptr),      32'h0);
        check("t1_gray",      32'(bus.wr_ptr_gray), 32'h0);
        check("t1_full",      32'(bus.f_full),      32'h0);
        check("t1_af",        32'(bus.almost_full), 32'h0);
        check("t1_ovf",       32'(bus.overflow),    32'h0);
        check("t1_accept",    32'(bus.wr_accept),   32'h1);

        // 2: sixteen back-to-back writes
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0);
            if (i == 13) check("t2_af_13",   32'(bus.almost_full), 32'h0);
            if (i == 14) check("t2_af_14",   32'(bus.almost_full), 32'h1);
            if (i == 15) check("t2_full_15", 32'(bus.f_full),      32'h0);
        end
        check("t2_wr_ptr", 32'(bus.wr_ptr),      32'h10);
        check("t2_msb",    32'(bus.MSB_wr_ptr),  32'h1);
        check("t2_b_ptr",  32'(bus.b_wr_ptr),    32'h0);
        check("t2_gray",   32'(bus.wr_ptr_gray), 32'h18);
        check("t2_full",   32'(bus.f_full),      32'h1);

        // 3: writes while full are refused and flagged
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            check("t3_accept", 32'(bus.wr_accept), 32'h0);
            check("t3_wr_ptr", 32'(bus.wr_ptr),    32'h10);
            check("t3_ovf",    32'(bus.overflow),  32'h1);
        end

        // 4: one read frees a slot after the synchroniser delay
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            n++;
            if (bus.f_full == 1'b0) break;
        end
        check("t4_release_edges", 32'(n), 32'd3);
        step(0, 1, 1);
        check("t4_wr_ptr", 32'(bus.wr_ptr), 32'h11);
        check("t4_refull", 32'(bus.f_full), 32'h1);

        // 5: 40 writes with the read side trailing closely
        step(1, 0, 0);
        rd_cur   = 0;
        wcnt     = 0;
        saw_full = 0;
        for (int i = 0; i < 40; i++) begin
            if (wcnt - rd_cur >= 4) rd_cur++;
            step(0, 1, rd_cur % MOD);
            wcnt++;
            if (bus.f_full == 1'b1) saw_full = 1;
        end
        rd_cur = rd_cur % MOD;
        check("t5_wr_ptr",  32'(bus.wr_ptr), 32'h08);
        check("t5_no_full", 32'(saw_full),   32'h0);

        // Random traffic: a filling phase followed by a draining phase
        for (int i = 0; i < 300; i++) begin
            bit we;
            bit rd_fast;
            rd_fast = (i >= 150);
            we = ($urandom_range(0, 3) != 0);
            if (rd_cur != m_ptr &&
                (rd_fast ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0)))
                rd_cur = (rd_cur + 1) % MOD;
            step(0, we, rd_cur);
        end

        // 6: reset pulse after five writes
        for (int i = 0; i < 5; i++) step(0, 1, rd_cur);
        step(1, 1, 3);
        check("t6_wr_ptr", 32'(bus.wr_ptr),      32'h0);
        check("t6_gray",   32'(bus.wr_ptr_gray), 32'h0);
        check("t6_ovf",    32'(bus.overflow),    32'h0);
        check("t6_full",   32'(bus.f_full),      32'h0);
        check("t6_af",     32'(bus.almost_full), 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        check("t6_after",  32'(bus.wr_ptr),      32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
